mode_sequencer: RTL and testbench
=================================

Name: mode_sequencer

Overview:
- Parametrised successor of the front-panel mode selector.
- Cycles the clock's operating mode (clock / alarm / stopwatch / set-time / extra modes) from debounced one-cycle key pulses.
- Adds forward and backward stepping, direct return to the home mode, a lock input and an idle timeout back to home.
- Sits between the key debouncers and the display/control mux; drives the mode bus and a one-cycle change strobe.

Parameters:
- NUM_MODES, 4, number of modes, legal range 2..16; modes are 0..NUM_MODES-1.
- MODE_W, 2, width of mode bus; must satisfy 2**MODE_W >= NUM_MODES.
- HOME_MODE, 0, mode entered on reset, on key_home and on timeout; must be < NUM_MODES.
- IDLE_TIMEOUT, 0, number of tick pulses without an accepted key before returning to HOME_MODE; 0 disables the timeout. Counter width is 16 bits, so max 65535.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_next  in  1  debounced one-cycle pulse: step mode forward.
- key_prev  in  1  debounced one-cycle pulse: step mode backward.
- key_home  in  1  debounced one-cycle pulse: jump to HOME_MODE.
- lock  in  1  high = ignore all keys and freeze the timeout counter (e.g. while editing a time field).
- tick  in  1  timeout time base, one-cycle pulse (e.g. 1 Hz strobe).
- mode  out  MODE_W  current mode, registered.
- mode_changed  out  1  one-cycle pulse, registered, high in the same cycle the new mode value first appears.
- wrapped  out  1  one-cycle pulse, high in the same cycle as mode_changed when a next/prev step wrapped across the 0 / NUM_MODES-1 boundary.

Behaviour:
- Reset (async, rst_n low): mode=HOME_MODE, mode_changed=0, wrapped=0, idle counter=0. Release is synchronous to clk; keys in the first cycle after release are honoured.
- All updates occur on the rising clk edge. Latency from a key pulse to the new mode is 1 cycle.
- Key acceptance requires lock=0. With lock=1, all keys are dropped (not queued).
- Priority when several events coincide:
  - key_home > (key_next XOR key_prev) > timeout.
  - key_next and key_prev together with no key_home: no step, but the event still counts as an accepted key (clears the idle counter); mode_changed=0.
- key_next: mode = mode+1; from NUM_MODES-1, mode wraps to 0 and wrapped=1.
- key_prev: mode = mode-1; from 0, mode wraps to NUM_MODES-1 and wrapped=1.
- key_home: mode=HOME_MODE; wrapped=0.
- mode_changed=1 only if the new mode differs from the old one. key_home while already at HOME_MODE gives no pulse. With NUM_MODES=2, a step always changes mode.
- Idle counter behaviour (IDLE_TIMEOUT>0):
  - Clears on any accepted key.
  - Held at 0 while mode==HOME_MODE.
  - Frozen while lock=1.
  - Otherwise increments on tick.
  - When tick arrives with counter==IDLE_TIMEOUT-1: mode=HOME_MODE, mode_changed=1, counter=0.
  - An accepted key in the same cycle as expiry wins: the key takes effect and the counter clears.
- IDLE_TIMEOUT=0: counter is held at 0 and no timeout ever occurs.
- The mode register never holds a value >= NUM_MODES.

Optional Feature:
- Macro: MODE_SKIP_EN.
- Defined:
  - Adds input skip_mask [NUM_MODES-1:0]; bit i=1 marks mode i as unavailable (e.g. alarm not fitted).
  - next/prev advance to the nearest unmasked mode in that direction, with wrap.
  - wrapped=1 if the search crossed the boundary.
  - If no other mode is unmasked, mode is unchanged and no pulses are raised.
  - HOME_MODE is reachable via key_home and timeout regardless of its mask bit.
  - The search is combinational, so the 1-cycle latency is kept.
- Undefined: no skip_mask port; plain modular stepping.

Test Plan:
- Reset with NUM_MODES=4, HOME_MODE=0 -> mode=0, mode_changed=0, wrapped=0; release, then key_next x4 on separate cycles -> mode 1,2,3,0; mode_changed pulses each time; wrapped=1 only on 3->0.
- mode=0, key_prev -> mode=3, wrapped=1; mode=2, key_next and key_prev in the same cycle -> mode stays 2, no pulses; mode=2, key_home and key_next together -> mode=0, mode_changed=1.
- lock=1 at mode=1, pulse key_next, key_prev, key_home -> mode stays 1, no pulses; lock=0, key_next -> mode=2 after 1 cycle.
- IDLE_TIMEOUT=3, mode=2, three ticks with no keys -> mode=0 with mode_changed on the third tick; repeat with key_next coinciding with the third tick -> mode=3, counter cleared, three more ticks -> mode=0.
- IDLE_TIMEOUT=3, mode=2, lock=1, five ticks -> mode stays 2; lock=0, three ticks -> mode=0. Assert rst_n low mid-count -> mode=0 immediately, counter=0.
- MODE_SKIP_EN with skip_mask=4'b0110, mode=0: key_next -> 3; key_next -> 0 with wrapped=1. With skip_mask=4'b1110 at mode 0: key_next -> no change, no pulses.

Source files
------------

// File: rtl/mode_sequencer.sv
// ---------------------------------------------------------------------------
// mode_sequencer
//
// Front-panel mode sequencer. It steps the operating mode forward or backward
// from debounced one-cycle key pulses, jumps to the home mode on key_home, and
// returns to the home mode after IDLE_TIMEOUT ticks with no accepted key.
// While lock is high, every key is dropped and the idle counter is frozen.
//
// Parameters:
//   NUM_MODES    number of modes (2..16); the legal modes are 0..NUM_MODES-1
//   MODE_W       width of the mode bus; 2**MODE_W >= NUM_MODES
//   HOME_MODE    mode entered on reset, on key_home and on timeout
//   IDLE_TIMEOUT ticks without an accepted key before returning home; 0 = off
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_next     one-cycle pulse: step forward
//   key_prev     one-cycle pulse: step backward
//   key_home     one-cycle pulse: jump to HOME_MODE
//   lock         drop all keys and freeze the idle counter
//   tick         timeout time base, one-cycle pulse
//   skip_mask    (MODE_SKIP_EN only) bit i = 1 marks mode i as unavailable
//   mode         current mode, registered
//   mode_changed one-cycle pulse in the first cycle a new mode value appears
//   wrapped      one-cycle pulse alongside mode_changed when a step crossed
//                the 0 / NUM_MODES-1 boundary
//
// Optional feature macro: MODE_SKIP_EN (adds skip_mask and masked stepping).
// ---------------------------------------------------------------------------
module mode_sequencer #(
   parameter int unsigned NUM_MODES    = 4,
   parameter int unsigned MODE_W       = 2,
   parameter int unsigned HOME_MODE    = 0,
   parameter int unsigned IDLE_TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_next,
   input  logic              key_prev,
   input  logic              key_home,
   input  logic              lock,
   input  logic              tick,
`ifdef MODE_SKIP_EN
   input  logic [NUM_MODES-1:0] skip_mask,
`endif
   output logic [MODE_W-1:0] mode,
   output logic              mode_changed,
   output logic              wrapped
);

   localparam logic [MODE_W-1:0] LastMode  = MODE_W'(NUM_MODES - 1);
   localparam logic [MODE_W-1:0] HomeMode  = MODE_W'(HOME_MODE);
   localparam bit                TimeoutEn = (IDLE_TIMEOUT != 0);
   // Only meaningful when TimeoutEn; every use is gated by it.
   localparam logic [15:0]       CntLast   = 16'(IDLE_TIMEOUT - 1);

   logic [MODE_W-1:0] mode_q, mode_d;
   logic              changed_q, changed_d;
   logic              wrapped_q, wrapped_d;
   logic [15:0]       cnt_q, cnt_d;

   logic              accept;
   logic              step_fwd, step_bwd;
   logic              at_home;
   logic              expire;

   logic [MODE_W-1:0] fwd_mode, bwd_mode;
   logic              fwd_wrap, bwd_wrap;
   logic              fwd_ok, bwd_ok;

   // A simultaneous next+prev is still an accepted key: it clears the idle
   // counter but produces no step.
   assign accept   = ~lock & (key_next | key_prev | key_home);
   assign step_fwd = accept & ~key_home & key_next & ~key_prev;
   assign step_bwd = accept & ~key_home & key_prev & ~key_next;
   assign at_home  = (mode_q == HomeMode);

   // Expiry loses to any accepted key in the same cycle.
   assign expire = TimeoutEn & ~lock & tick & ~at_home & ~accept & (cnt_q == CntLast);

`ifdef MODE_SKIP_EN
   // Nearest unmasked mode in each direction. The search starts one step
   // away, so the current mode is never a candidate; if every other mode is
   // masked the step is suppressed (fwd_ok/bwd_ok stay low).
   logic [15:0] mask_ext;
   assign mask_ext = 16'(skip_mask);

   always_comb begin : skip_search
      int fi;
      int bi;
      fwd_ok   = 1'b0;
      fwd_mode = mode_q;
      fwd_wrap = 1'b0;
      bwd_ok   = 1'b0;
      bwd_mode = mode_q;
      bwd_wrap = 1'b0;
      for (int k = 1; k < int'(NUM_MODES); k++) begin
         fi = int'(mode_q) + k;
         if (fi >= int'(NUM_MODES)) begin
            fi = fi - int'(NUM_MODES);
         end
         if (!fwd_ok && !mask_ext[fi[3:0]]) begin
            fwd_ok   = 1'b1;
            fwd_mode = MODE_W'(fi);
            fwd_wrap = (int'(mode_q) + k >= int'(NUM_MODES));
         end
         bi = int'(mode_q) - k;
         if (bi < 0) begin
            bi = bi + int'(NUM_MODES);
         end
         if (!bwd_ok && !mask_ext[bi[3:0]]) begin
            bwd_ok   = 1'b1;
            bwd_mode = MODE_W'(bi);
            bwd_wrap = (int'(mode_q) - k < 0);
         end
      end
   end
`else
   // Plain modular stepping; every step is possible.
   always_comb begin : plain_step
      fwd_ok = 1'b1;
      bwd_ok = 1'b1;
      if (mode_q == LastMode) begin
         fwd_mode = '0;
         fwd_wrap = 1'b1;
      end else begin
         fwd_mode = mode_q + MODE_W'(1);
         fwd_wrap = 1'b0;
      end
      if (mode_q == '0) begin
         bwd_mode = LastMode;
         bwd_wrap = 1'b1;
      end else begin
         bwd_mode = mode_q - MODE_W'(1);
         bwd_wrap = 1'b0;
      end
   end
`endif

   // Next mode: key_home > single step > timeout.
   always_comb begin : next_mode
      mode_d    = mode_q;
      wrapped_d = 1'b0;
      if (accept && key_home) begin
         mode_d = HomeMode;
      end else if (step_fwd && fwd_ok) begin
         mode_d    = fwd_mode;
         wrapped_d = fwd_wrap;
      end else if (step_bwd && bwd_ok) begin
         mode_d    = bwd_mode;
         wrapped_d = bwd_wrap;
      end else if (expire) begin
         mode_d = HomeMode;
      end
      changed_d = (mode_d != mode_q);
   end

   // Idle counter: cleared by keys, parked at 0 in the home mode, frozen by
   // lock, otherwise counts ticks and restarts at expiry.
   always_comb begin : next_cnt
      cnt_d = cnt_q;
      if (!TimeoutEn || accept || at_home) begin
         cnt_d = '0;
      end else if (lock) begin
         cnt_d = cnt_q;
      end else if (tick) begin
         cnt_d = expire ? '0 : cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= HomeMode;
         changed_q <= 1'b0;
         wrapped_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         mode_q    <= mode_d;
         changed_q <= changed_d;
         wrapped_q <= wrapped_d;
         cnt_q     <= cnt_d;
      end
   end

   assign mode         = mode_q;
   assign mode_changed = changed_q;
   assign wrapped      = wrapped_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mode_sequencer
//
// Directed, table-driven bench for mode_sequencer. DUT "a" uses NUM_MODES=4,
// HOME_MODE=0, IDLE_TIMEOUT=3; DUT "b" uses NUM_MODES=3, HOME_MODE=1 with the
// timeout disabled. Each vector drives one cycle of inputs and lists the
// outputs expected right after the following rising edge.
// ---------------------------------------------------------------------------
module tb_mode_sequencer;

   typedef struct {
      logic       n;
      logic       p;
      logic       h;
      logic       lk;
      logic       tk;
      logic [1:0] m;
      logic       c;
      logic       w;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_next, a_prev, a_home, a_lock, a_tick;
   logic       b_next, b_prev, b_home, b_lock, b_tick;
   logic [1:0] a_mode, b_mode;
   logic       a_chg, a_wrap, b_chg, b_wrap;
`ifdef MODE_SKIP_EN
   logic [3:0] a_skip;
   logic [2:0] b_skip;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mode_sequencer #(
      .NUM_MODES(4), .MODE_W(2), .HOME_MODE(0), .IDLE_TIMEOUT(3)
   ) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_next    (a_next),
      .key_prev    (a_prev),
      .key_home    (a_home),
      .lock        (a_lock),
      .tick        (a_tick),
`ifdef MODE_SKIP_EN
      .skip_mask   (a_skip),
`endif
      .mode        (a_mode),
      .mode_changed(a_chg),
      .wrapped     (a_wrap)
   );

   mode_sequencer #(
      .NUM_MODES(3), .MODE_W(2), .HOME_MODE(1), .IDLE_TIMEOUT(0)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_next    (b_next),
      .key_prev    (b_prev),
      .key_home    (b_home),
      .lock        (b_lock),
      .tick        (b_tick),
`ifdef MODE_SKIP_EN
      .skip_mask   (b_skip),
`endif
      .mode        (b_mode),
      .mode_changed(b_chg),
      .wrapped     (b_wrap)
   );

   function automatic vec_t mk(input bit n, input bit p, input bit h, input bit lk,
                               input bit tk, input int m, input bit c, input bit w);
      vec_t v;
      v.n  = n;
      v.p  = p;
      v.h  = h;
      v.lk = lk;
      v.tk = tk;
      v.m  = 2'(m);
      v.c  = c;
      v.w  = w;
      return v;
   endfunction

   task automatic check(input string tag, input int idx, input logic [1:0] got_m,
                        input logic got_c, input logic got_w, input vec_t v);
      n_tests++;
      if (got_m !== v.m) begin
         n_fail++;
         $display("FAIL %s[%0d] mode: got %0d, want %0d", tag, idx, got_m, v.m);
      end
      n_tests++;
      if (got_c !== v.c) begin
         n_fail++;
         $display("FAIL %s[%0d] mode_changed: got %b, want %b", tag, idx, got_c, v.c);
      end
      n_tests++;
      if (got_w !== v.w) begin
         n_fail++;
         $display("FAIL %s[%0d] wrapped: got %b, want %b", tag, idx, got_w, v.w);
      end
   endtask

   // Drive one vector on the falling edge, check just after the rising edge.
   task automatic run_vec(input bit sel_b, input string tag, input int idx, input vec_t v);
      @(negedge clk);
      if (sel_b) begin
         b_next = v.n; b_prev = v.p; b_home = v.h; b_lock = v.lk; b_tick = v.tk;
      end else begin
         a_next = v.n; a_prev = v.p; a_home = v.h; a_lock = v.lk; a_tick = v.tk;
      end
      @(posedge clk);
      #1;
      if (sel_b) check(tag, idx, b_mode, b_chg, b_wrap, v);
      else       check(tag, idx, a_mode, a_chg, a_wrap, v);
   endtask

   vec_t va[$];
   vec_t vb[$];
   vec_t vr[$];

   initial begin
      rst_n  = 1'b0;
      a_next = 0; a_prev = 0; a_home = 0; a_lock = 0; a_tick = 0;
      b_next = 0; b_prev = 0; b_home = 0; b_lock = 0; b_tick = 0;
`ifdef MODE_SKIP_EN
      a_skip = '0;
      b_skip = '0;
`endif

      //             n  p  h lk tk  mode chg wrap
      va.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0));
      va.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0));
      va.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1)); // 3 -> 0 wraps
      va.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      va.push_back(mk(0, 1, 0, 0, 0, 3, 1, 1)); // 0 -> 3 wraps
      va.push_back(mk(0, 1, 0, 0, 0, 2, 1, 0));
      va.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0)); // next+prev cancel
      va.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0)); // home beats next
      va.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0)); // home at home: no pulse
      va.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0));
      va.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0)); // locked keys dropped
      va.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0));
      va.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0));
      va.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0));
      va.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0)); // idle 1
      va.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0)); // idle 2
      va.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0)); // timeout
      va.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0)); // home: counter parked
      va.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0));
      va.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0));
      va.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0));
      va.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0));
      va.push_back(mk(1, 0, 0, 0, 1, 3, 1, 0)); // key wins over expiry
      va.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0));
      va.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0));
      va.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0)); // timeout after restart
      va.push_back(mk(0, 1, 0, 0, 0, 3, 1, 1));
      va.push_back(mk(0, 1, 0, 0, 0, 2, 1, 0));
      for (int i = 0; i < 5; i++) begin
         va.push_back(mk(0, 0, 0, 1, 1, 2, 0, 0)); // lock freezes counter
      end
      va.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0));
      va.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0));
      va.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
      va.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0));
      va.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
      va.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
      va.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0)); // next+prev clears counter
      va.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
      va.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
      va.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0)); // frozen at 2
      va.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0)); // resumes and expires
      va.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

      // DUT b: three modes, home 1, timeout disabled.
      vb.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0));
      vb.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1)); // 2 -> 0 wraps
      vb.push_back(mk(0, 1, 0, 0, 0, 2, 1, 1)); // 0 -> 2 wraps
      vb.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0));
      vb.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < 4; i++) begin
         vb.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0)); // no timeout
      end
      vb.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0));
      vb.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0));
      vb.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
      vb.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));

      // Reset values while rst_n is held low.
      repeat (2) @(posedge clk);
      #1;
      check("rst_a", 0, a_mode, a_chg, a_wrap, mk(0, 0, 0, 0, 0, 0, 0, 0));
      check("rst_b", 0, b_mode, b_chg, b_wrap, mk(0, 0, 0, 0, 0, 1, 0, 0));

      // Release and press key_next in the very first cycle after release.
      @(negedge clk);
      rst_n  = 1'b1;
      a_next = 1'b1;
      @(posedge clk);
      #1;
      check("release", 0, a_mode, a_chg, a_wrap, mk(0, 0, 0, 0, 0, 1, 1, 0));

      foreach (va[i]) run_vec(1'b0, "vec_a", i, va[i]);

      // Asynchronous reset mid-count, right after a change pulse.
      vr.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0));
      vr.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0));
      vr.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0));
      vr.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0));
      vr.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0));
      foreach (vr[i]) run_vec(1'b0, "pre_rst", i, vr[i]);
      @(negedge clk);
      a_next = 0; a_prev = 0; a_home = 0; a_lock = 0; a_tick = 0;
      rst_n  = 1'b0;
      #1;
      check("async_rst", 0, a_mode, a_chg, a_wrap, mk(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(1'b0, "post_rst", 0, mk(0, 0, 0, 0, 1, 0, 0, 0));
      run_vec(1'b0, "post_rst", 1, mk(0, 1, 0, 0, 0, 3, 1, 1));
      run_vec(1'b0, "post_rst", 2, mk(0, 0, 1, 0, 0, 0, 1, 0));

      foreach (vb[i]) run_vec(1'b1, "vec_b", i, vb[i]);

`ifdef MODE_SKIP_EN
      // Masked stepping on DUT a, starting from mode 0.
      a_skip = 4'b0110;
      run_vec(1'b0, "skip", 0, mk(1, 0, 0, 0, 0, 3, 1, 0));
      run_vec(1'b0, "skip", 1, mk(1, 0, 0, 0, 0, 0, 1, 1));
      run_vec(1'b0, "skip", 2, mk(0, 1, 0, 0, 0, 3, 1, 1));
      run_vec(1'b0, "skip", 3, mk(0, 1, 0, 0, 0, 0, 1, 0));
      a_skip = 4'b1110;
      run_vec(1'b0, "skip", 4, mk(1, 0, 0, 0, 0, 0, 0, 0));
      run_vec(1'b0, "skip", 5, mk(0, 1, 0, 0, 0, 0, 0, 0));
      a_skip = 4'b0001;
      run_vec(1'b0, "skip", 6, mk(1, 0, 0, 0, 0, 1, 1, 0));
      run_vec(1'b0, "skip", 7, mk(0, 0, 1, 0, 0, 0, 1, 0)); // masked home reachable
      a_skip = 4'b0000;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
